// File: rtl/x2050_pkg.sv
// Shared definitions for the 2050 break-in request stage.
// Holds the arbiter state type, routine bit indices and the default delay.
package x2050_pkg;

    localparam int NREQ        = 4;
    localparam int DLY_DEFAULT = 3;

    // Routine request bit positions; bit 0 has the highest priority.
    localparam int RTN0 = 0;
    localparam int RTN1 = 1;
    localparam int RTN2 = 2;
    localparam int RTN3 = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RECD    = 2'd2,
        WAITFC  = 2'd3
    } brq_state_t;

endpackage

// File: rtl/x2050brq_if.sv
// Request/acknowledge bundle between the break-in request stage and
// the ROS/channel side. slave = x2050brq, master = the driving side.
interface x2050brq_if;
    import x2050_pkg::*;

    logic            i_ros_advance;
    logic [NREQ-1:0] i_chan_req;
    logic [NREQ-1:0] i_sched_req;
    logic            i_mem_busy;
    logic            i_routine_recd;
    logic            i_firstcycle;
    logic [NREQ-1:0] o_routine_requesting;
    logic [NREQ-1:0] o_pending;
    logic [NREQ-1:0] o_delay_active;
    logic            o_busy;

    modport master (
        output i_ros_advance, i_chan_req, i_sched_req,
        output i_mem_busy, i_routine_recd, i_firstcycle,
        input  o_routine_requesting, o_pending,
        input  o_delay_active, o_busy
    );

    modport slave (
        input  i_ros_advance, i_chan_req, i_sched_req,
        input  i_mem_busy, i_routine_recd, i_firstcycle,
        output o_routine_requesting, o_pending,
        output o_delay_active, o_busy
    );

endinterface

// File: rtl/x2050brq_dly.sv
// One delayed-request counter. A schedule pulse loads DLY; each ROS
// advance counts down and the 1->0 step raises o_expire for that cycle.
// Ports: i_clk, i_reset, i_adv, i_sched in; o_active, o_expire out.
module x2050brq_dly
    import x2050_pkg::*;
#(
    parameter int DLY = DLY_DEFAULT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_adv,
    input  logic i_sched,
    output logic o_active,
    output logic o_expire
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        o_expire = 1'b0;
        if (i_adv) begin
            // A fresh schedule always restarts, even mid-count.
            if (i_sched) begin
                cnt_d = 4'(DLY);
            end else if (cnt_q != 4'd0) begin
                cnt_d    = cnt_q - 4'd1;
                o_expire = (cnt_q == 4'd1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign o_active = (cnt_q != 4'd0);

endmodule

// File: rtl/x2050brq.sv
// Break-in request stage: latches immediate and delayed routine
// requests, grants the lowest-index one and holds it one-hot until the
// ROS acknowledges with routine-received and first-cycle.
// Ports: i_clk, i_reset (async, active-high); brq bundle (slave side).
module x2050brq
    import x2050_pkg::*;
#(
    parameter int DLY = DLY_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    x2050brq_if.slave   brq
);

    brq_state_t      state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] req_q, req_d;
    logic            busy_q, busy_d;
    logic [NREQ-1:0] active;
    logic [NREQ-1:0] expire;
    logic [NREQ-1:0] pick;
    logic [NREQ-1:0] clr;

    for (genvar g = 0; g < NREQ; g++) begin : g_dly
        x2050brq_dly #(.DLY(DLY)) u_dly (
            .i_clk    (i_clk),
            .i_reset  (i_reset),
            .i_adv    (brq.i_ros_advance),
            .i_sched  (brq.i_sched_req[g]),
            .o_active (active[g]),
            .o_expire (expire[g])
        );
    end

    // Lowest set bit of pending wins.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        clr     = '0;
        if (brq.i_ros_advance) begin
            unique case (state_q)
                IDLE: begin
                    if (pending_q != '0 && !brq.i_mem_busy) begin
                        grant_d = pick;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    if (brq.i_routine_recd) begin
                        clr     = grant_q;
                        state_d = RECD;
                    end
                end
                RECD: begin
                    if (!brq.i_routine_recd)
                        state_d = brq.i_firstcycle ? IDLE : WAITFC;
                end
                WAITFC: begin
                    if (brq.i_firstcycle) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // New requests are ORed in after the acknowledge clear: set wins.
    always_comb begin
        pending_d = pending_q;
        if (brq.i_ros_advance)
            pending_d = (pending_q & ~clr) | brq.i_chan_req | expire;
    end

    always_comb begin
        req_d  = '0;
        busy_d = (state_d != IDLE);
        if (state_d == PRESENT || state_d == RECD) req_d = grant_d;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            pending_q <= '0;
            req_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
        end
    end

    assign brq.o_routine_requesting = req_q;
    assign brq.o_pending            = pending_q;
    assign brq.o_delay_active       = active;
    assign brq.o_busy               = busy_q;

endmodule

// File: tb/tb_x2050brq.sv
// Testbench for x2050brq: directed scenarios plus a randomized run
// against a behavioural model of pending, delays and the handshake.
module tb_x2050brq;
    import x2050_pkg::*;

    localparam int TB_DLY = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    x2050brq_if bus();

    x2050brq #(.DLY(TB_DLY)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .brq     (bus)
    );

    // Model: pending bits, remaining delay per routine, presented
    // routine and handshake phase (0 none, 1 shown, 2 received, 3 wait fc).
    bit [3:0] m_pend;
    int       m_cnt[4];
    int       m_grant;
    int       m_phase;

    task automatic model_reset();
        m_pend  = '0;
        m_grant = 0;
        m_phase = 0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        bit [3:0] old, exp_b, clr;
        int pick;
        if (rst || !bus.i_ros_advance) return;
        old   = m_pend;
        exp_b = '0;
        clr   = '0;
        for (int i = 0; i < 4; i++) begin
            if (bus.i_sched_req[i]) m_cnt[i] = TB_DLY;
            else if (m_cnt[i] > 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) exp_b[i] = 1'b1;
            end
        end
        case (m_phase)
            0: if (old != 0 && !bus.i_mem_busy) begin
                pick = 0;
                for (int i = 3; i >= 0; i--) if (old[i]) pick = i;
                m_grant = pick;
                m_phase = 1;
            end
            1: if (bus.i_routine_recd) begin
                clr[m_grant] = 1'b1;
                m_phase = 2;
            end
            2: if (!bus.i_routine_recd) m_phase = bus.i_firstcycle ? 0 : 3;
            3: if (bus.i_firstcycle) m_phase = 0;
            default: m_phase = 0;
        endcase
        m_pend = (old & ~clr) | bus.i_chan_req | exp_b;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_ros_advance  = 1'b1;
        bus.i_chan_req     = '0;
        bus.i_sched_req    = '0;
        bus.i_mem_busy     = 1'b0;
        bus.i_routine_recd = 1'b0;
        bus.i_firstcycle   = 1'b0;
    endtask

    task automatic hs();
        bus.i_routine_recd = 1'b1; tick();
        bus.i_routine_recd = 1'b0; tick();
        bus.i_firstcycle   = 1'b1; tick();
        bus.i_firstcycle   = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        bus.i_chan_req  = 4'hF;
        bus.i_sched_req = 4'hF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_run++; if (bus.o_routine_requesting !== 4'h0) begin n_fail++; $display("FAIL reset_req got %h exp 0", bus.o_routine_requesting); end
        n_run++; if (bus.o_pending !== 4'h0) begin n_fail++; $display("FAIL reset_pend got %h exp 0", bus.o_pending); end
        n_run++; if (bus.o_delay_active !== 4'h0) begin n_fail++; $display("FAIL reset_act got %h exp 0", bus.o_delay_active); end
        n_run++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.o_busy); end
        clear_inputs();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_single();
        repeat (3) tick();
        bus.i_chan_req = 4'h4; tick();
        n_run++; if (bus.o_pending !== 4'h4) begin n_fail++; $display("FAIL single_pend got %h exp 4", bus.o_pending); end
        n_run++; if (bus.o_routine_requesting !== 4'h0) begin n_fail++; $display("FAIL single_early got %h exp 0", bus.o_routine_requesting); end
        bus.i_chan_req = 4'h0; tick();
        n_run++; if (bus.o_routine_requesting !== 4'h4) begin n_fail++; $display("FAIL single_req got %h exp 4", bus.o_routine_requesting); end
        bus.i_routine_recd = 1'b1; tick();
        n_run++; if (bus.o_pending !== 4'h0) begin n_fail++; $display("FAIL single_clr got %h exp 0", bus.o_pending); end
        tick();
        n_run++; if (bus.o_routine_requesting !== 4'h4) begin n_fail++; $display("FAIL single_recd got %h exp 4", bus.o_routine_requesting); end
        bus.i_routine_recd = 1'b0; tick();
        n_run++; if (bus.o_routine_requesting !== 4'h0) begin n_fail++; $display("FAIL single_drop got %h exp 0", bus.o_routine_requesting); end
        n_run++; if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL single_waitfc got %b exp 1", bus.o_busy); end
        bus.i_firstcycle = 1'b1; tick();
        bus.i_firstcycle = 1'b0;
        n_run++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got %b exp 0", bus.o_busy); end
    endtask

    task automatic test_priority();
        bus.i_chan_req = 4'hA; tick();
        bus.i_chan_req = 4'h0; tick();
        n_run++; if (bus.o_routine_requesting !== 4'h2) begin n_fail++; $display("FAIL prio_first got %h exp 2", bus.o_routine_requesting); end
        bus.i_chan_req = 4'h1; tick();
        bus.i_chan_req = 4'h0;
        n_run++; if (bus.o_routine_requesting !== 4'h2) begin n_fail++; $display("FAIL prio_nopreempt got %h exp 2", bus.o_routine_requesting); end
        n_run++; if (bus.o_pending !== 4'hB) begin n_fail++; $display("FAIL prio_pend got %h exp b", bus.o_pending); end
        bus.i_routine_recd = 1'b1; tick();
        n_run++; if (bus.o_pending !== 4'h9) begin n_fail++; $display("FAIL prio_clr got %h exp 9", bus.o_pending); end
        bus.i_routine_recd = 1'b0; tick();
        bus.i_firstcycle = 1'b1; tick();
        bus.i_firstcycle = 1'b0; tick();
        n_run++; if (bus.o_routine_requesting !== 4'h1) begin n_fail++; $display("FAIL prio_second got %h exp 1", bus.o_routine_requesting); end
        hs(); tick();
        n_run++; if (bus.o_routine_requesting !== 4'h8) begin n_fail++; $display("FAIL prio_third got %h exp 8", bus.o_routine_requesting); end
        hs();
        n_run++; if (bus.o_pending !== 4'h0) begin n_fail++; $display("FAIL prio_done got %h exp 0", bus.o_pending); end
    endtask

    task automatic test_membusy();
        bus.i_mem_busy = 1'b1;
        bus.i_chan_req = 4'h1; tick();
        bus.i_chan_req = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_run++; if (bus.o_routine_requesting !== 4'h0 || bus.o_pending !== 4'h1) begin n_fail++; $display("FAIL busy_block req %h pend %h exp 0/1", bus.o_routine_requesting, bus.o_pending); end
        end
        bus.i_mem_busy = 1'b0; tick();
        n_run++; if (bus.o_routine_requesting !== 4'h1) begin n_fail++; $display("FAIL busy_release got %h exp 1", bus.o_routine_requesting); end
        hs();
    endtask

    task automatic test_delay();
        bus.i_sched_req = 4'h2; tick();
        bus.i_sched_req = 4'h0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            n_run++; if (bus.o_delay_active !== 4'h2 || bus.o_pending !== 4'h0) begin n_fail++; $display("FAIL dly_run%0d act %h pend %h exp 2/0", k, bus.o_delay_active, bus.o_pending); end
        end
        tick();
        n_run++; if (bus.o_pending !== 4'h2 || bus.o_delay_active !== 4'h0) begin n_fail++; $display("FAIL dly_expire pend %h act %h exp 2/0", bus.o_pending, bus.o_delay_active); end
        tick();
        n_run++; if (bus.o_routine_requesting !== 4'h2) begin n_fail++; $display("FAIL dly_grant got %h exp 2", bus.o_routine_requesting); end
        hs();
        bus.i_sched_req = 4'h2; tick();
        bus.i_sched_req = 4'h0; tick();
        bus.i_sched_req = 4'h2; tick();
        bus.i_sched_req = 4'h0; tick(); tick();
        n_run++; if (bus.o_pending !== 4'h0 || bus.o_delay_active !== 4'h2) begin n_fail++; $display("FAIL dly_restart pend %h act %h exp 0/2", bus.o_pending, bus.o_delay_active); end
        tick();
        n_run++; if (bus.o_pending !== 4'h2) begin n_fail++; $display("FAIL dly_restart_exp got %h exp 2", bus.o_pending); end
        tick(); hs();
    endtask

    task automatic test_hold();
        bus.i_chan_req = 4'h4; tick();
        bus.i_chan_req = 4'h0; tick();
        bus.i_ros_advance  = 1'b0;
        bus.i_routine_recd = 1'b1;
        bus.i_chan_req     = 4'h1;
        bus.i_sched_req    = 4'h1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_run++; if (bus.o_routine_requesting !== 4'h4 || bus.o_pending !== 4'h4 || bus.o_delay_active !== 4'h0 || bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL hold%0d req %h pend %h act %h busy %b exp 4/4/0/1", k, bus.o_routine_requesting, bus.o_pending, bus.o_delay_active, bus.o_busy); end
        end
        clear_inputs();
        bus.i_routine_recd = 1'b1;
        bus.i_chan_req     = 4'h4; tick();
        bus.i_chan_req     = 4'h0;
        n_run++; if (bus.o_pending !== 4'h4) begin n_fail++; $display("FAIL setwins got %h exp 4", bus.o_pending); end
        bus.i_routine_recd = 1'b0; tick();
        bus.i_firstcycle = 1'b1; tick();
        bus.i_firstcycle = 1'b0; tick();
        n_run++; if (bus.o_routine_requesting !== 4'h4) begin n_fail++; $display("FAIL setwins_regrant got %h exp 4", bus.o_routine_requesting); end
        hs();
    endtask

    task automatic test_reset_mid();
        bus.i_chan_req = 4'h1; tick();
        bus.i_chan_req = 4'h0; tick();
        bus.i_routine_recd = 1'b1;
        bus.i_sched_req    = 4'h8; tick();
        bus.i_sched_req    = 4'h0;
        #2;
        rst = 1'b1;
        #1;
        n_run++; if (bus.o_routine_requesting !== 4'h0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_state req %h busy %b exp 0/0", bus.o_routine_requesting, bus.o_busy); end
        n_run++; if (bus.o_pending !== 4'h0 || bus.o_delay_active !== 4'h0) begin n_fail++; $display("FAIL rstmid_regs pend %h act %h exp 0/0", bus.o_pending, bus.o_delay_active); end
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.i_chan_req = 4'h8; tick();
        bus.i_chan_req = 4'h0;
        n_run++; if (bus.o_pending !== 4'h8 || bus.o_routine_requesting !== 4'h0) begin n_fail++; $display("FAIL rstmid_edge1 pend %h req %h exp 8/0", bus.o_pending, bus.o_routine_requesting); end
        tick();
        n_run++; if (bus.o_routine_requesting !== 4'h8) begin n_fail++; $display("FAIL rstmid_edge2 got %h exp 8", bus.o_routine_requesting); end
        hs();
    endtask

    task automatic test_random();
        bit [3:0] e_req, e_act;
        for (int c = 0; c < 600; c++) begin
            bus.i_ros_advance  = ($urandom_range(0, 7) != 0);
            bus.i_chan_req     = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            bus.i_sched_req    = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            bus.i_mem_busy     = ($urandom_range(0, 3) == 0);
            bus.i_routine_recd = ($urandom_range(0, 1) == 0);
            bus.i_firstcycle   = ($urandom_range(0, 2) == 0);
            tick();
            e_req = (m_phase == 1 || m_phase == 2) ? 4'(1 << m_grant) : 4'h0;
            e_act = '0;
            for (int i = 0; i < 4; i++) e_act[i] = (m_cnt[i] > 0);
            n_run++; if (bus.o_routine_requesting !== e_req) begin n_fail++; $display("FAIL rnd_req c%0d got %h exp %h", c, bus.o_routine_requesting, e_req); end
            n_run++; if (bus.o_pending !== m_pend) begin n_fail++; $display("FAIL rnd_pend c%0d got %h exp %h", c, bus.o_pending, m_pend); end
            n_run++; if (bus.o_delay_active !== e_act) begin n_fail++; $display("FAIL rnd_act c%0d got %h exp %h", c, bus.o_delay_active, e_act); end
            n_run++; if (bus.o_busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got %b exp %b", c, bus.o_busy, (m_phase != 0)); end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_priority();
        test_membusy();
        test_delay();
        test_hold();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
